// File: rtl/alu_decode_stage.sv
// alu_decode_stage: registered MIPS32 ALU-class decoder feeding execute through a one-entry skid buffer.
// Define DECODE_R2_ROT_EN to decode ROTR/ROTRV; otherwise they are reported as illegal.
module alu_decode_stage (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_instr,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [10:0] o_alu_ctrl,
  output logic [4:0]  o_sh_amount,
  output logic [31:0] o_imm,
  output logic        o_b_imm,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_dest,
  output logic        o_reg_write,
  output logic        o_illegal,
  output logic [15:0] o_illegal_cnt
);

  // Control words: {alu_sel, sh_op, lui, log_op, ar_op_en, ar_op, slt_op}
  localparam logic [10:0] CTRL_SLL   = 11'h000;
  localparam logic [10:0] CTRL_ROR   = 11'h040;
  localparam logic [10:0] CTRL_SRL   = 11'h080;
  localparam logic [10:0] CTRL_SRA   = 11'h0C0;
  localparam logic [10:0] CTRL_SLLV  = 11'h100;
  localparam logic [10:0] CTRL_RORV  = 11'h140;
  localparam logic [10:0] CTRL_SRLV  = 11'h180;
  localparam logic [10:0] CTRL_SRAV  = 11'h1C0;
  localparam logic [10:0] CTRL_LUI   = 11'h020;
  localparam logic [10:0] CTRL_SLT   = 11'h202;
  localparam logic [10:0] CTRL_SLTU  = 11'h203;
  localparam logic [10:0] CTRL_ADDU  = 11'h400;
  localparam logic [10:0] CTRL_SUBU  = 11'h402;
  localparam logic [10:0] CTRL_ADD   = 11'h404;
  localparam logic [10:0] CTRL_SUB   = 11'h406;
  localparam logic [10:0] CTRL_AND   = 11'h600;
  localparam logic [10:0] CTRL_OR    = 11'h608;
  localparam logic [10:0] CTRL_XOR   = 11'h610;
  localparam logic [10:0] CTRL_NOR   = 11'h618;

  localparam int DW = 66;

  logic [5:0]    opcode_s, funct_s;
  logic [4:0]    rs_s, rt_s, rd_s, sa_s, dest_s;
  logic [31:0]   sext_s, zext_s, imm_s;
  logic [10:0]   ctrl_s;
  logic          b_imm_s, legal_s, accept_s, out_free_s;
  logic [DW-1:0] dec_s, out_r, skid_r;
  logic          out_valid_r, skid_valid_r, ready_r;
  logic [15:0]   ill_cnt_r;

  assign opcode_s = i_instr[31:26];
  assign rs_s     = i_instr[25:21];
  assign rt_s     = i_instr[20:16];
  assign rd_s     = i_instr[15:11];
  assign sa_s     = i_instr[10:6];
  assign funct_s  = i_instr[5:0];
  assign sext_s   = {{16{i_instr[15]}}, i_instr[15:0]};
  assign zext_s   = {16'h0000, i_instr[15:0]};

  // Instruction decode into control word, immediate and destination
  always_comb begin
    ctrl_s  = 11'h000;
    imm_s   = 32'h0000_0000;
    b_imm_s = 1'b0;
    legal_s = 1'b1;
    dest_s  = rd_s;
    if (opcode_s == 6'h00) begin
      case (funct_s)
        6'h00: ctrl_s = CTRL_SLL;
        6'h02: begin
          // rs field selects SRL (0) or ROTR (1); anything else is reserved
          if (rs_s == 5'd0) begin
            ctrl_s = CTRL_SRL;
          end else if (rs_s == 5'd1) begin
`ifdef DECODE_R2_ROT_EN
            ctrl_s = CTRL_ROR;
`else
            legal_s = 1'b0;
`endif
          end else begin
            legal_s = 1'b0;
          end
        end
        6'h03: ctrl_s = CTRL_SRA;
        6'h04: ctrl_s = CTRL_SLLV;
        6'h06: begin
          if (sa_s == 5'd0) begin
            ctrl_s = CTRL_SRLV;
          end else if (sa_s == 5'd1) begin
`ifdef DECODE_R2_ROT_EN
            ctrl_s = CTRL_RORV;
`else
            legal_s = 1'b0;
`endif
          end else begin
            legal_s = 1'b0;
          end
        end
        6'h07: ctrl_s = CTRL_SRAV;
        6'h20: ctrl_s = CTRL_ADD;
        6'h21: ctrl_s = CTRL_ADDU;
        6'h22: ctrl_s = CTRL_SUB;
        6'h23: ctrl_s = CTRL_SUBU;
        6'h24: ctrl_s = CTRL_AND;
        6'h25: ctrl_s = CTRL_OR;
        6'h26: ctrl_s = CTRL_XOR;
        6'h27: ctrl_s = CTRL_NOR;
        6'h2A: ctrl_s = CTRL_SLT;
        6'h2B: ctrl_s = CTRL_SLTU;
        default: legal_s = 1'b0;
      endcase
    end else begin
      dest_s  = rt_s;
      b_imm_s = 1'b1;
      case (opcode_s)
        6'h08: begin ctrl_s = CTRL_ADD;  imm_s = sext_s; end
        6'h09: begin ctrl_s = CTRL_ADDU; imm_s = sext_s; end
        6'h0A: begin ctrl_s = CTRL_SLT;  imm_s = sext_s; end
        6'h0B: begin ctrl_s = CTRL_SLTU; imm_s = sext_s; end
        6'h0C: begin ctrl_s = CTRL_AND;  imm_s = zext_s; end
        6'h0D: begin ctrl_s = CTRL_OR;   imm_s = zext_s; end
        6'h0E: begin ctrl_s = CTRL_XOR;  imm_s = zext_s; end
        6'h0F: begin ctrl_s = CTRL_LUI;  imm_s = zext_s; end
        default: legal_s = 1'b0;
      endcase
    end
  end

  // Illegal encodings keep the raw register/shift fields but drop all control
  assign dec_s = {legal_s ? ctrl_s : 11'h000, sa_s, legal_s ? imm_s : 32'h0000_0000,
                  b_imm_s & legal_s, rs_s, rt_s, dest_s, legal_s, ~legal_s};

  assign accept_s   = i_valid & ready_r;
  assign out_free_s = ~out_valid_r | i_ready;

  // Output register and skid entry; the skid always refills the output before new input
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      out_r        <= {DW{1'b0}};
      skid_r       <= {DW{1'b0}};
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      ready_r      <= 1'b1;
    end else if (out_free_s) begin
      if (skid_valid_r) begin
        out_r        <= skid_r;
        out_valid_r  <= 1'b1;
        skid_valid_r <= 1'b0;
        ready_r      <= 1'b1;
      end else if (accept_s) begin
        out_r       <= dec_s;
        out_valid_r <= 1'b1;
      end else begin
        out_valid_r <= 1'b0;
      end
    end else if (accept_s) begin
      skid_r       <= dec_s;
      skid_valid_r <= 1'b1;
      ready_r      <= 1'b0;
    end
  end

  // Saturating count of accepted illegal instructions
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ill_cnt_r <= 16'h0000;
    end else if (accept_s && !legal_s && ill_cnt_r != 16'hFFFF) begin
      ill_cnt_r <= ill_cnt_r + 16'h0001;
    end
  end

  assign o_ready       = ready_r;
  assign o_valid       = out_valid_r;
  assign o_alu_ctrl    = out_r[65:55];
  assign o_sh_amount   = out_r[54:50];
  assign o_imm         = out_r[49:18];
  assign o_b_imm       = out_r[17];
  assign o_rs          = out_r[16:12];
  assign o_rt          = out_r[11:7];
  assign o_dest        = out_r[6:2];
  assign o_reg_write   = out_r[1];
  assign o_illegal     = out_r[0];
  assign o_illegal_cnt = ill_cnt_r;

endmodule
